// File: rtl/ddr3_arb_pkg.sv
// Shared constants for the DDR3 RAM-port arbiter.
package ddr3_arb_pkg;

  localparam int DDR3_DATA_W = 128;
  localparam int DDR3_STRB_W = 16;
  localparam int DDR3_ID_W   = 16;
  localparam int DDR3_ADDR_W = 32;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ddr3_arb_tag_fifo.sv
// In-order FIFO of granted port indices; the head names the port owed the next response.
module ddr3_arb_tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ddr3_ram_arb.sv
// N-to-1 arbiter in front of a single DDR3 core RAM port.
// Optional macro DDR3_ARB_PRIO_EN: port 0 gets strict priority when unlocked,
// ports 1..PORTS-1 round-robin among themselves.
module ddr3_ram_arb
  import ddr3_arb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [PORTS*DDR3_STRB_W-1:0] inport_wr_i,
  input  logic [PORTS-1:0]             inport_rd_i,
  input  logic [PORTS*DDR3_ID_W-1:0]   inport_req_id_i,
  input  logic [PORTS*DDR3_ADDR_W-1:0] inport_addr_i,
  input  logic [PORTS*DDR3_DATA_W-1:0] inport_write_data_i,
  output logic [PORTS-1:0]             inport_accept_o,
  output logic [PORTS-1:0]             inport_ack_o,
  output logic [PORTS-1:0]             inport_error_o,
  output logic [DDR3_DATA_W-1:0]       inport_read_data_o,
  output logic [DDR3_ID_W-1:0]         inport_resp_id_o,
  output logic [DDR3_STRB_W-1:0]       outport_wr_o,
  output logic                         outport_rd_o,
  output logic [DDR3_ID_W-1:0]         outport_req_id_o,
  output logic [DDR3_ADDR_W-1:0]       outport_addr_o,
  output logic [DDR3_DATA_W-1:0]       outport_write_data_o,
  input  logic                         outport_accept_i,
  input  logic                         outport_ack_i,
  input  logic                         outport_error_i,
  input  logic [DDR3_DATA_W-1:0]       outport_read_data_i,
  input  logic [DDR3_ID_W-1:0]         outport_resp_id_i,
  output logic [$clog2(DEPTH+1)-1:0]   outstanding_o,
  output logic                         protocol_err_o
);

  localparam int IDX_W = idx_w(PORTS);

  logic [PORTS-1:0] req;
  logic [IDX_W-1:0] pick, win, head;
  logic             pick_vld, fwd_vld, show, fire, ack_vld;
  logic             fifo_full, fifo_empty;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic             perr_q, perr_d;
  logic [PORTS-1:0] win_oh, head_oh;

  // A port is requesting when it has a read or any write strobe set.
  always_comb begin
    for (int p = 0; p < PORTS; p++)
      req[p] = inport_rd_i[p] | (|inport_wr_i[p*DDR3_STRB_W +: DDR3_STRB_W]);
  end

  // Pick the first requester at or after the round-robin pointer.
  always_comb begin
    int cand;
    cand     = 0;
    pick     = '0;
    pick_vld = 1'b0;
`ifdef DDR3_ARB_PRIO_EN
    if (req[0]) begin
      pick_vld = 1'b1;
    end else begin
      for (int i = 0; i < PORTS-1; i++) begin
        cand = (rr_q == '0) ? 1 + i : int'(rr_q) + i;
        if (cand >= PORTS) cand = cand - (PORTS-1);
        if (!pick_vld && req[cand]) begin
          pick_vld = 1'b1;
          pick     = IDX_W'(cand);
        end
      end
    end
`else
    for (int i = 0; i < PORTS; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= PORTS) cand = cand - PORTS;
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(cand);
      end
    end
`endif
  end

  // A held grant overrides fresh arbitration so the offered request stays stable.
  assign win     = lock_q ? grant_q : pick;
  assign fwd_vld = ~rst_i & (lock_q ? req[grant_q] : pick_vld);
  assign show    = fwd_vld & ~fifo_full;
  assign fire    = show & outport_accept_i;
  assign ack_vld = ~rst_i & outport_ack_i & ~fifo_empty;

  // One-hot decode of the winner and of the port owed the current response.
  always_comb begin
    win_oh       = '0;
    head_oh      = '0;
    win_oh[win]  = 1'b1;
    head_oh[head] = 1'b1;
  end

  // Request mux to the core; everything is zero when nothing is offered.
  always_comb begin
    outport_wr_o         = '0;
    outport_rd_o         = 1'b0;
    outport_req_id_o     = '0;
    outport_addr_o       = '0;
    outport_write_data_o = '0;
    if (show) begin
      outport_wr_o         = inport_wr_i[int'(win)*DDR3_STRB_W +: DDR3_STRB_W];
      outport_rd_o         = inport_rd_i[win];
      outport_req_id_o     = inport_req_id_i[int'(win)*DDR3_ID_W +: DDR3_ID_W];
      outport_addr_o       = inport_addr_i[int'(win)*DDR3_ADDR_W +: DDR3_ADDR_W];
      outport_write_data_o = inport_write_data_i[int'(win)*DDR3_DATA_W +: DDR3_DATA_W];
    end
  end

  assign inport_accept_o    = fire ? win_oh : '0;
  assign inport_ack_o       = ack_vld ? head_oh : '0;
  assign inport_error_o     = (ack_vld & outport_error_i) ? head_oh : '0;
  assign inport_read_data_o = rst_i ? '0 : outport_read_data_i;
  assign inport_resp_id_o   = rst_i ? '0 : outport_resp_id_i;
  assign protocol_err_o     = perr_q;

  // Lock while an offer waits; advance the pointer past each accepted winner.
  always_comb begin
    lock_d  = fwd_vld & ~fire;
    grant_d = fwd_vld ? win : grant_q;
    rr_d    = rr_q;
    if (fire) rr_d = (int'(win) == PORTS-1) ? '0 : win + 1'b1;
    perr_d  = perr_q | (outport_ack_i & fifo_empty);
  end

  // Arbitration and error-flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_q  <= 1'b0;
      grant_q <= '0;
      rr_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      lock_q  <= lock_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      perr_q  <= perr_d;
    end
  end

  ddr3_arb_tag_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fire),
    .data_i  (win),
    .pop_i   (ack_vld),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule
